// File: rtl/hba_arb_pkg.sv
// hba_arb_pkg: shared state encoding and sizing for the HBA round-robin arbiter
package hba_arb_pkg;
    localparam int MAX_MASTERS = 4;
    localparam int OWNER_W = $clog2(MAX_MASTERS);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;
endpackage

// File: rtl/hba_rr_pick.sv
// hba_rr_pick: combinational rotating-priority encoder, search starts one past last_owner
module hba_rr_pick
    import hba_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [MAX_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]     last_owner,
    output logic [OWNER_W-1:0]     winner,
    output logic                   valid
);
    // Walk from the farthest candidate inwards so the nearest one after last_owner wins.
    always_comb begin
        winner = '0;
        valid = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (req[(int'(last_owner) + i) % NUM_MASTERS]) begin
                winner = OWNER_W'((int'(last_owner) + i) % NUM_MASTERS);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hba_rr_arbiter.sv
// hba_rr_arbiter: round-robin HBA bus arbiter; optional watchdog via HBA_ARB_WATCHDOG_EN
module hba_rr_arbiter
    import hba_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_WIDTH       = 16
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset,
    input  logic [MAX_MASTERS-1:0] hba_mrequest,
    input  logic                   hba_select,
    input  logic                   hba_xferack,
    output logic [MAX_MASTERS-1:0] hba_mgrant,
    output logic [OWNER_W-1:0]     arb_owner,
    output logic                   arb_busy,
    output logic                   arb_timeout
);
    localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(NUM_MASTERS - 1);

    arb_state_e state_q, state_d;
    logic [MAX_MASTERS-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic busy_q, busy_d;
    logic [OWNER_W-1:0] pick_idx;
    logic pick_vld;
    logic owner_req;
    logic wd_fire;

    hba_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req        (hba_mrequest),
        .last_owner (owner_q),
        .winner     (pick_idx),
        .valid      (pick_vld)
    );

    assign owner_req = hba_mrequest[owner_q];

    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= OWNER_RST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    // Grant/transfer share one exit rule: hold while selected, park while still requested.
    always_comb begin
        state_d = state_q;
        if (wd_fire) state_d = ST_RELEASE;
        else begin
            unique case (state_q)
                ST_IDLE:    state_d = pick_vld ? ST_GRANT : ST_IDLE;
                ST_GRANT,
                ST_XFER:    state_d = hba_select ? ST_XFER : (owner_req ? ST_GRANT : ST_RELEASE);
                ST_RELEASE: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        if (state_q == ST_IDLE && pick_vld) begin
            grant_d = MAX_MASTERS'(1) << pick_idx;
            owner_d = pick_idx;
        end else if (state_d == ST_RELEASE) begin
            grant_d = '0;
        end
        busy_d = |grant_d;
    end

    assign hba_mgrant = grant_q;
    assign arb_owner  = owner_q;
    assign arb_busy   = busy_q;

`ifdef HBA_ARB_WATCHDOG_EN
    logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic timeout_q, timeout_d;
    logic wd_active;

    assign wd_active = (state_q == ST_GRANT) || (state_q == ST_XFER);
    // An ack in the limit cycle suppresses the timeout.
    assign wd_fire = wd_active && !hba_xferack && (wd_cnt_q >= TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_d = (!wd_active || hba_xferack || (state_d == ST_GRANT && state_q != ST_GRANT)) ? '0 :
                   (&wd_cnt_q ? wd_cnt_q : wd_cnt_q + 1'b1);
        timeout_d = wd_fire;
    end

    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb_timeout = timeout_q;
`else
    logic unused_wd;
    assign unused_wd = ^{hba_xferack, TO_WIDTH[0], TIMEOUT_CYCLES[0]};
    assign wd_fire = 1'b0;
    assign arb_timeout = 1'b0;
`endif
endmodule
